// File: rtl/alsu_if.sv
// Operand, control and result signals of the ALSU, grouped so the board-side driver
// and the unit share one bundle.
interface alsu_if;
    logic [2:0]  A;
    logic [2:0]  B;
    logic [2:0]  opcode;
    logic        cin;
    logic        serial_in;
    logic        direction;
    logic        red_op_A;
    logic        red_op_B;
    logic        bypass_A;
    logic        bypass_B;
    logic [5:0]  out;
    logic [15:0] leds;

    modport master (
        output A, B, opcode, cin, serial_in, direction,
        output red_op_A, red_op_B, bypass_A, bypass_B,
        input  out, leds
    );

    modport slave (
        input  A, B, opcode, cin, serial_in, direction,
        input  red_op_A, red_op_B, bypass_A, bypass_B,
        output out, leds
    );
endinterface

// File: rtl/alsu_unit.sv
// Two-stage registered ALSU: inputs captured in stage 1, result and status LEDs
// computed from the captured values into stage 2.
module alsu_unit #(
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON"
) (
    input logic   clk,
    input logic   rst,
    alsu_if.slave bus
);
    localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
    localparam bit USE_CIN = (FULL_ADDER == "ON");

    logic [2:0]  r_a_p0;
    logic [2:0]  r_b_p0;
    logic [2:0]  r_opcode_p0;
    logic        r_cin_p0;
    logic        r_sin_p0;
    logic        r_dir_p0;
    logic        r_red_a_p0;
    logic        r_red_b_p0;
    logic        r_byp_a_p0;
    logic        r_byp_b_p0;
    logic [5:0]  r_out_p1;
    logic [15:0] r_leds_p1;

    logic        w_red_any;
    logic        w_invalid;
    logic        w_byp_pick_a;
    logic        w_red_pick_a;
    logic [5:0]  w_a_ext;
    logic [5:0]  w_b_ext;
    logic [5:0]  w_out_nxt;
    logic [15:0] w_leds_nxt;

    // Stage 1: capture every input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_p0      <= '0;
            r_b_p0      <= '0;
            r_opcode_p0 <= '0;
            r_cin_p0    <= 1'b0;
            r_sin_p0    <= 1'b0;
            r_dir_p0    <= 1'b0;
            r_red_a_p0  <= 1'b0;
            r_red_b_p0  <= 1'b0;
            r_byp_a_p0  <= 1'b0;
            r_byp_b_p0  <= 1'b0;
        end else begin
            r_a_p0      <= bus.A;
            r_b_p0      <= bus.B;
            r_opcode_p0 <= bus.opcode;
            r_cin_p0    <= bus.cin;
            r_sin_p0    <= bus.serial_in;
            r_dir_p0    <= bus.direction;
            r_red_a_p0  <= bus.red_op_A;
            r_red_b_p0  <= bus.red_op_B;
            r_byp_a_p0  <= bus.bypass_A;
            r_byp_b_p0  <= bus.bypass_B;
        end
    end

    assign w_a_ext      = {3'b000, r_a_p0};
    assign w_b_ext      = {3'b000, r_b_p0};
    assign w_red_any    = r_red_a_p0 | r_red_b_p0;
    assign w_invalid    = (r_opcode_p0 == 3'd6) || (r_opcode_p0 == 3'd7) ||
                          (w_red_any && (r_opcode_p0 > 3'd1));
    // When both flags of a pair are set, the configured priority operand wins
    assign w_byp_pick_a = r_byp_a_p0 && (!r_byp_b_p0 || PRIO_A);
    assign w_red_pick_a = r_red_a_p0 && (!r_red_b_p0 || PRIO_A);

    always_comb begin
        w_out_nxt  = r_out_p1;
        w_leds_nxt = '0;
        if (r_byp_a_p0 || r_byp_b_p0) begin
            w_out_nxt = w_byp_pick_a ? w_a_ext : w_b_ext;
        end else if (w_invalid) begin
            w_out_nxt  = '0;
            w_leds_nxt = ~r_leds_p1;
        end else begin
            case (r_opcode_p0)
                3'd0: begin
                    if (w_red_any)
                        w_out_nxt = {5'b00000, (w_red_pick_a ? (&r_a_p0) : (&r_b_p0))};
                    else
                        w_out_nxt = w_a_ext & w_b_ext;
                end
                3'd1: begin
                    if (w_red_any)
                        w_out_nxt = {5'b00000, (w_red_pick_a ? (^r_a_p0) : (^r_b_p0))};
                    else
                        w_out_nxt = w_a_ext ^ w_b_ext;
                end
                3'd2: w_out_nxt = w_a_ext + w_b_ext + {5'b00000, (r_cin_p0 & USE_CIN)};
                3'd3: w_out_nxt = w_a_ext * w_b_ext;
                3'd4: w_out_nxt = r_dir_p0 ? {r_out_p1[4:0], r_sin_p0}
                                           : {r_sin_p0, r_out_p1[5:1]};
                3'd5: w_out_nxt = r_dir_p0 ? {r_out_p1[4:0], r_out_p1[5]}
                                           : {r_out_p1[0], r_out_p1[5:1]};
                default: w_out_nxt = '0;
            endcase
        end
    end

    // Stage 2: result and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_p1  <= '0;
            r_leds_p1 <= '0;
        end else begin
            r_out_p1  <= w_out_nxt;
            r_leds_p1 <= w_leds_nxt;
        end
    end

    assign bus.out  = r_out_p1;
    assign bus.leds = r_leds_p1;
endmodule

// File: tb/tb_alsu_unit.sv
// Directed bench for alsu_unit: each step drives one input set and queues the
// hand-computed result, which is checked when it emerges two edges later.
module tb_alsu_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    alsu_if bus ();

    alsu_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [5:0]  q_out[$];
    logic [15:0] q_leds[$];
    string       q_tag[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic check_front();
        logic [5:0]  e_out;
        logic [15:0] e_leds;
        string       tag;
        e_out  = q_out.pop_front();
        e_leds = q_leds.pop_front();
        tag    = q_tag.pop_front();
        n_cmp++;
        assert (bus.out === e_out) else begin
            n_fail++;
            $error("FAIL %s out: got %0d, expected %0d", tag, bus.out, e_out);
        end
        n_cmp++;
        assert (bus.leds === e_leds) else begin
            n_fail++;
            $error("FAIL %s leds: got %h, expected %h", tag, bus.leds, e_leds);
        end
    endtask

    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                        input logic c, input logic sin, input logic dir,
                        input logic ra, input logic rb, input logic ba, input logic bb,
                        input logic [5:0] e_out, input logic [15:0] e_leds, input string tag);
        bus.A         = a;
        bus.B         = b;
        bus.opcode    = op;
        bus.cin       = c;
        bus.serial_in = sin;
        bus.direction = dir;
        bus.red_op_A  = ra;
        bus.red_op_B  = rb;
        bus.bypass_A  = ba;
        bus.bypass_B  = bb;
        q_out.push_back(e_out);
        q_leds.push_back(e_leds);
        q_tag.push_back(tag);
        @(posedge clk);
        #1;
        if (q_out.size() >= 2) check_front();
    endtask

    initial begin
        bus.A = 3'd0; bus.B = 3'd0; bus.opcode = 3'd0; bus.cin = 1'b0;
        bus.serial_in = 1'b0; bus.direction = 1'b0; bus.red_op_A = 1'b0;
        bus.red_op_B = 1'b0; bus.bypass_A = 1'b0; bus.bypass_B = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        assert (bus.out === 6'd0) else begin
            n_fail++;
            $error("FAIL reset_out: got %0d, expected 0", bus.out);
        end
        n_cmp++;
        assert (bus.leds === 16'h0000) else begin
            n_fail++;
            $error("FAIL reset_leds: got %h, expected 0000", bus.leds);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Stage-1 registers hold zeros from reset: opcode 0 on A=B=0 gives 0
        q_out.push_back(6'd0);
        q_leds.push_back(16'h0000);
        q_tag.push_back("post_reset");

        //   A     B     op    cin   sin   dir   rA    rB    bA    bB    out    leds
        step(3'd5, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd5,  16'h0000, "bypass_both");
        step(3'd5, 3'd2, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2,  16'h0000, "bypass_B_invalid_op");
        step(3'd6, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd6,  16'h0000, "bypass_A_invalid_red");
        step(3'd7, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3,  16'h0000, "and_ab");
        step(3'd7, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1,  16'h0000, "and_red_A");
        step(3'd7, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  16'h0000, "and_red_B");
        step(3'd6, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  16'h0000, "and_red_both");
        step(3'd5, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd6,  16'h0000, "xor_ab");
        step(3'd7, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1,  16'h0000, "xor_red_both");
        step(3'd3, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1,  16'h0000, "xor_red_B");
        step(3'd7, 3'd7, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd15, 16'h0000, "add_max_cin");
        step(3'd3, 3'd4, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd7,  16'h0000, "add_no_cin");
        step(3'd7, 3'd7, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd49, 16'h0000, "mul_max");
        step(3'd5, 3'd6, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd30, 16'h0000, "mul_5x6");
        step(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  16'h0000, "clear_out");
        step(3'd0, 3'd0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1,  16'h0000, "shl_1");
        step(3'd0, 3'd0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3,  16'h0000, "shl_2");
        step(3'd0, 3'd0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd7,  16'h0000, "shl_3");
        step(3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3,  16'h0000, "shr_0");
        step(3'd0, 3'd0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd33, 16'h0000, "shr_1");
        step(3'd1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1,  16'h0000, "set_one");
        step(3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd32, 16'h0000, "rotr_1");
        step(3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd16, 16'h0000, "rotr_2");
        step(3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd32, 16'h0000, "rotl_1");
        step(3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1,  16'h0000, "rotl_wrap");
        step(3'd7, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  16'hFFFF, "inv_op7_a");
        step(3'd7, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  16'h0000, "inv_op7_b");
        step(3'd3, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  16'hFFFF, "inv_red_add");
        step(3'd1, 3'd1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  16'h0000, "inv_op6");
        step(3'd1, 3'd1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  16'hFFFF, "inv_red_rot");
        step(3'd1, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2,  16'h0000, "recover_add");

        // Drain the last queued result
        @(posedge clk);
        #1;
        while (q_out.size() > 0) begin
            check_front();
            if (q_out.size() > 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
